// File: rtl/frame_deserializer.sv
// Serial-to-parallel deserializer with sync-word frame alignment.
// Hunts for SYNC_WORD, emits FRAME_WORDS payload words per frame and re-checks sync with a flywheel.
module frame_deserializer #(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] SYNC_WORD   = 32'hA5A5_F00F,
  parameter int                FRAME_WORDS = 4,
  parameter int                MISS_LIMIT  = 2,
  parameter bit                MSB_FIRST   = 1'b1,
  localparam int               IDX_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [IDX_W-1:0]  word_idx,
  output logic              frame_start,
  output logic              locked,
  output logic              sync_err
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [CW-1:0]    LAST_BIT  = CW'(DATA_W - 1);
  localparam logic [CW-1:0]    FILL_FULL = CW'(DATA_W);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(FRAME_WORDS - 1);
  localparam logic [MW-1:0]    MISS_MAX  = MW'(MISS_LIMIT);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shifted;
  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     fill_cnt;
  logic [IDX_W-1:0]  word_cnt;
  logic [MW-1:0]     miss_cnt;
  logic [MW-1:0]     miss_next;
  logic              word_done;
  logic              fill_ok;
  logic              sync_hit;

  always_comb begin
    shifted = shift_reg;
    if (MSB_FIRST) begin
      shifted = {shift_reg[DATA_W-2:0], data_in};
    end else begin
      shifted = {data_in, shift_reg[DATA_W-1:1]};
    end
    word_done = (bit_cnt == LAST_BIT);
    // The bit being sampled now completes a full window when DATA_W-1 bits are already in.
    fill_ok   = (fill_cnt >= LAST_BIT);
    sync_hit  = (shifted == SYNC_WORD);
    miss_next = miss_cnt + MW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      fill_cnt    <= '0;
      word_cnt    <= '0;
      miss_cnt    <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      word_idx    <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      if (bit_en) begin
        shift_reg <= shifted;
        if (fill_cnt != FILL_FULL) begin
          fill_cnt <= fill_cnt + CW'(1);
        end
        case (state)
          HUNT: begin
            if (fill_ok && sync_hit) begin
              state    <= PAYLOAD;
              locked   <= 1'b1;
              bit_cnt  <= '0;
              word_cnt <= '0;
              miss_cnt <= '0;
            end
          end
          PAYLOAD: begin
            if (word_done) begin
              bit_cnt     <= '0;
              data_out    <= shifted;
              data_valid  <= 1'b1;
              word_idx    <= word_cnt;
              frame_start <= (word_cnt == '0);
              if (word_cnt == LAST_WORD) begin
                word_cnt <= '0;
                state    <= CHECK;
              end else begin
                word_cnt <= word_cnt + IDX_W'(1);
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          CHECK: begin
            if (word_done) begin
              bit_cnt <= '0;
              if (sync_hit) begin
                miss_cnt <= '0;
                state    <= PAYLOAD;
              end else begin
                sync_err <= 1'b1;
                miss_cnt <= miss_next;
                // Too many consecutive misses: drop lock and demand a fresh full window.
                if (miss_next == MISS_MAX) begin
                  state    <= HUNT;
                  locked   <= 1'b0;
                  fill_cnt <= '0;
                  miss_cnt <= '0;
                end else begin
                  state <= PAYLOAD;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_deserializer.sv
// Scoreboard bench: three deserializer configurations driven from a bit-history reference model.
module tb_frame_deserializer;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int          idx;
    bit          fs;
  } exp_t;

  localparam int MISS = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic en[3];
  logic din[3];

  always #5 clk = ~clk;

  logic [7:0]  dout_a, dout_b;
  logic [31:0] dout_c;
  logic [0:0]  idx_a, idx_b;
  logic [1:0]  idx_c;
  logic dv_a, dv_b, dv_c, fs_a, fs_b, fs_c, lk_a, lk_b, lk_c, err_a, err_b, err_c;

  frame_deserializer #(.DATA_W(8), .SYNC_WORD(8'hA5), .FRAME_WORDS(2), .MISS_LIMIT(2), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bit_en(en[0]), .data_in(din[0]), .data_out(dout_a), .data_valid(dv_a),
    .word_idx(idx_a), .frame_start(fs_a), .locked(lk_a), .sync_err(err_a));

  frame_deserializer #(.DATA_W(8), .SYNC_WORD(8'hA5), .FRAME_WORDS(2), .MISS_LIMIT(2), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bit_en(en[1]), .data_in(din[1]), .data_out(dout_b), .data_valid(dv_b),
    .word_idx(idx_b), .frame_start(fs_b), .locked(lk_b), .sync_err(err_b));

  frame_deserializer #(.DATA_W(32), .SYNC_WORD(32'hA5A5_F00F), .FRAME_WORDS(4), .MISS_LIMIT(2), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bit_en(en[2]), .data_in(din[2]), .data_out(dout_c), .data_valid(dv_c),
    .word_idx(idx_c), .frame_start(fs_c), .locked(lk_c), .sync_err(err_c));

  logic [31:0] dout[3];
  logic [1:0]  idxv[3];
  logic        dvv[3], fsv[3], lkv[3], errv[3];
  assign dout[0] = {24'd0, dout_a};
  assign dout[1] = {24'd0, dout_b};
  assign dout[2] = dout_c;
  assign idxv[0] = {1'b0, idx_a};
  assign idxv[1] = {1'b0, idx_b};
  assign idxv[2] = idx_c;
  assign dvv[0] = dv_a;  assign dvv[1] = dv_b;  assign dvv[2] = dv_c;
  assign fsv[0] = fs_a;  assign fsv[1] = fs_b;  assign fsv[2] = fs_c;
  assign lkv[0] = lk_a;  assign lkv[1] = lk_b;  assign lkv[2] = lk_c;
  assign errv[0] = err_a; assign errv[1] = err_b; assign errv[2] = err_c;

  int          pw[3]     = '{8, 8, 32};
  bit          pmsb[3]   = '{1'b1, 1'b0, 1'b1};
  int          pframe[3] = '{2, 2, 4};
  logic [31:0] psync[3]  = '{32'h0000_00A5, 32'h0000_00A5, 32'hA5A5_F00F};

  // Reference model: history of received bits (index 0 newest) plus frame bookkeeping.
  int          mst[3];
  int          fill[3];
  int          bitc[3];
  int          wordc[3];
  int          miss[3];
  logic [31:0] hist[3];
  exp_t        sbq[3][$];
  int          n_valid[3];
  logic        last_en[3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] assembled(input int k);
    logic [31:0] r = '0;
    for (int p = 0; p < pw[k]; p++) begin
      r[p] = pmsb[k] ? hist[k][p] : hist[k][pw[k]-1-p];
    end
    return r;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mst[k] = 0; fill[k] = 0; bitc[k] = 0; wordc[k] = 0; miss[k] = 0;
      hist[k] = '0;
      sbq[k].delete();
    end
  endtask

  task automatic modelBit(input int k, input logic b);
    logic [31:0] word;
    exp_t        e;
    hist[k] = {hist[k][30:0], b};
    if (fill[k] < pw[k]) fill[k]++;
    word = assembled(k);
    case (mst[k])
      0: begin
        if (fill[k] == pw[k] && word == psync[k]) begin
          mst[k] = 1; bitc[k] = 0; wordc[k] = 0; miss[k] = 0;
        end
      end
      1: begin
        bitc[k]++;
        if (bitc[k] == pw[k]) begin
          bitc[k] = 0;
          e.is_err = 1'b0; e.data = word; e.idx = wordc[k]; e.fs = (wordc[k] == 0);
          sbq[k].push_back(e);
          wordc[k]++;
          if (wordc[k] == pframe[k]) begin
            wordc[k] = 0;
            mst[k] = 2;
          end
        end
      end
      default: begin
        bitc[k]++;
        if (bitc[k] == pw[k]) begin
          bitc[k] = 0;
          if (word == psync[k]) begin
            miss[k] = 0;
            mst[k] = 1;
          end else begin
            e.is_err = 1'b1; e.data = '0; e.idx = 0; e.fs = 1'b0;
            sbq[k].push_back(e);
            miss[k]++;
            if (miss[k] == MISS) begin
              mst[k] = 0; fill[k] = 0; miss[k] = 0;
            end else begin
              mst[k] = 1;
            end
          end
        end
      end
    endcase
  endtask

  task automatic checkOutput(input int k, input logic dv, input logic [31:0] d, input logic [1:0] idx,
                             input logic fs, input logic err);
    exp_t e;
    if (!dv && fs) checkVal($sformatf("k%0d frame_start_without_valid", k), 32'(fs), 32'd0);
    if (!dv && !err) return;
    checkVal($sformatf("k%0d pulse_after_enabled_edge", k), 32'(last_en[k]), 32'd1);
    if (sbq[k].size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL k%0d unexpected_pulse: got valid=%b err=%b data=%h expected no pulse", k, dv, err, d);
      return;
    end
    e = sbq[k].pop_front();
    if (e.is_err) begin
      checkVal($sformatf("k%0d sync_err_pulse", k), {30'd0, err, dv}, 32'd2);
    end else begin
      n_valid[k]++;
      checkVal($sformatf("k%0d valid_pulse", k), {30'd0, dv, err}, 32'd2);
      checkVal($sformatf("k%0d data_out", k), d, e.data);
      checkVal($sformatf("k%0d word_idx", k), 32'(idx), 32'(e.idx));
      checkVal($sformatf("k%0d frame_start", k), 32'(fs), 32'(e.fs));
    end
  endtask

  always @(posedge clk) begin
    last_en[0] <= en[0];
    last_en[1] <= en[1];
    last_en[2] <= en[2];
  end

  // Monitor: pops the scoreboard whenever any instance presents a pulse.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      checkOutput(k, dvv[k], dout[k], idxv[k], fsv[k], errv[k]);
    end
  end

  task automatic applyStimulus(input int k, input logic b, input logic e);
    din[k] = b;
    en[k]  = e;
    if (e) modelBit(k, b);
    @(posedge clk);
    #1;
    checkVal($sformatf("k%0d locked", k), 32'(lkv[k]), 32'(mst[k] != 0));
  endtask

  task automatic sendWord(input int k, input logic [31:0] v, input int gap);
    logic b;
    for (int i = 0; i < pw[k]; i++) begin
      b = pmsb[k] ? v[pw[k]-1-i] : v[i];
      applyStimulus(k, b, 1'b1);
      if (gap == 1 && (i % 2) == 1) begin
        repeat (3) applyStimulus(k, 1'($urandom), 1'b0);
      end else if (gap == 2 && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) applyStimulus(k, 1'($urandom), 1'b0);
      end
    end
  endtask

  task automatic drain(input int k);
    repeat (4) applyStimulus(k, 1'b0, 1'b0);
    checkVal($sformatf("k%0d scoreboard_drained", k), 32'(sbq[k].size()), 32'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en[k]  = 1'b0;
      din[k] = 1'b0;
    end
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic randomRun(input int k, input int nwords);
    int          slot;
    logic [31:0] mask;
    logic [31:0] v;
    mask = (pw[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << pw[k]) - 32'd1);
    sendWord(k, psync[k], 2);
    slot = 0;
    repeat (nwords) begin
      if (slot == pframe[k]) begin
        v = psync[k];
        if ($urandom_range(0, 2) == 0) v = v ^ (32'd1 << $urandom_range(0, pw[k] - 1));
        slot = 0;
      end else begin
        v = $urandom & mask;
        slot++;
      end
      sendWord(k, v, 2);
    end
    drain(k);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] base;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en[k]  = 1'b0;
      din[k] = 1'b0;
    end
    modelReset();
    #3;
    for (int k = 0; k < 3; k++) begin
      checkVal($sformatf("k%0d reset data_out", k), dout[k], 32'd0);
      checkVal($sformatf("k%0d reset flags", k), {27'd0, dvv[k], fsv[k], lkv[k], errv[k], 1'b0}, 32'd0);
      checkVal($sformatf("k%0d reset word_idx", k), 32'(idxv[k]), 32'd0);
    end
    doReset();

    $display("[TB] lock and payload");
    sendWord(0, 32'hA5, 0); sendWord(0, 32'h3C, 0); sendWord(0, 32'hC3, 0);
    sendWord(0, 32'hA5, 0); sendWord(0, 32'h11, 0); sendWord(0, 32'h22, 0);
    drain(0);

    $display("[TB] misaligned hunt");
    doReset();
    applyStimulus(0, 1'b1, 1'b1); applyStimulus(0, 1'b0, 1'b1); applyStimulus(0, 1'b1, 1'b1);
    sendWord(0, 32'hA5, 0); sendWord(0, 32'h55, 0); sendWord(0, 32'hAA, 0);
    drain(0);

    $display("[TB] flywheel then loss");
    doReset();
    sendWord(0, 32'hA5, 0); sendWord(0, 32'h10, 0); sendWord(0, 32'h20, 0);
    sendWord(0, 32'h00, 0); sendWord(0, 32'h01, 0); sendWord(0, 32'h02, 0);
    sendWord(0, 32'hFF, 0);
    checkVal("k0 unlocked_after_second_miss", 32'(lk_a), 32'd0);
    sendWord(0, 32'hA5, 0); sendWord(0, 32'h33, 0); sendWord(0, 32'h44, 0);
    drain(0);

    $display("[TB] lsb-first with bit_en gaps");
    doReset();
    n_valid[1] = 0;
    sendWord(1, 32'hA5, 1); sendWord(1, 32'h3C, 1);
    drain(1);
    checkVal("k1 single_valid", 32'(n_valid[1]), 32'd1);
    checkVal("k1 data_held", 32'(dout_b), 32'h3C);

    $display("[TB] reset mid-word");
    doReset();
    sendWord(0, 32'hA5, 0); sendWord(0, 32'h77, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'(i % 2), 1'b1);
    checkVal("k0 data_before_reset", 32'(dout_a), 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("k0 async_reset data_out", 32'(dout_a), 32'd0);
    checkVal("k0 async_reset locked", 32'(lk_a), 32'd0);
    checkVal("k0 async_reset pulses", {29'd0, dv_a, fs_a, err_a}, 32'd0);
    doReset();
    sendWord(0, 32'hA5, 0); sendWord(0, 32'h96, 0);
    drain(0);

    $display("[TB] 32-bit width scaling");
    doReset();
    n_valid[2] = 0;
    base = $urandom;
    sendWord(2, psync[2], 0);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) sendWord(2, base + 32'(f * 4 + i), 0);
      if (f == 0) sendWord(2, psync[2], 0);
    end
    drain(2);
    checkVal("k2 valid_count", 32'(n_valid[2]), 32'd8);

    $display("[TB] randomized streams");
    doReset();
    randomRun(0, 30);
    doReset();
    randomRun(1, 30);
    doReset();
    randomRun(2, 12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
